// File: rtl/wb_reg_file_if.sv
// MEM/WB-to-register-file bus: write-back sources, destination, ID-stage read ports
// and commit status. The master drives the pipeline side; the slave is the register file.
interface wb_reg_file_if #(
    parameter int WORD_LEN  = 32,
    parameter int ADDR_LEN  = 5,
    parameter int COUNT_LEN = 32
);
    logic [WORD_LEN-1:0]  mem_read_data;
    logic [WORD_LEN-1:0]  alu_result;
    logic [WORD_LEN-1:0]  next_pc;
    logic                 less_than;
    logic [1:0]           reg_data_sel;
    logic [ADDR_LEN-1:0]  reg_dest;
    logic                 reg_write_en;
    logic [ADDR_LEN-1:0]  read_reg1;
    logic [ADDR_LEN-1:0]  read_reg2;
    logic [WORD_LEN-1:0]  read_data1;
    logic [WORD_LEN-1:0]  read_data2;
    logic [WORD_LEN-1:0]  wb_data;
    logic                 wb_valid;
    logic [COUNT_LEN-1:0] commit_count;

    modport master (
        output mem_read_data, alu_result, next_pc, less_than, reg_data_sel,
               reg_dest, reg_write_en, read_reg1, read_reg2,
        input  read_data1, read_data2, wb_data, wb_valid, commit_count
    );

    modport slave (
        input  mem_read_data, alu_result, next_pc, less_than, reg_data_sel,
               reg_dest, reg_write_en, read_reg1, read_reg2,
        output read_data1, read_data2, wb_data, wb_valid, commit_count
    );
endinterface

// File: rtl/wb_reg_file.sv
// Write-back stage and register file: selects the write-back value, commits it,
// serves two read ports with same-cycle bypass and counts committed writes.
module wb_reg_file #(
    parameter int WORD_LEN  = 32,
    parameter int ADDR_LEN  = 5,
    parameter int REG_COUNT = 32,
    parameter int COUNT_LEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    wb_reg_file_if.slave    bus
);

    function automatic logic [WORD_LEN-1:0] wb_select(
        input logic [1:0]          sel,
        input logic [WORD_LEN-1:0] alu,
        input logic [WORD_LEN-1:0] mem,
        input logic [WORD_LEN-1:0] pc,
        input logic                lt
    );
        logic [WORD_LEN-1:0] res;
        case (sel)
            2'b00:   res = alu;
            2'b01:   res = mem;
            2'b10:   res = pc;
            2'b11:   res = {{(WORD_LEN-1){1'b0}}, lt};
            default: res = alu;
        endcase
        return res;
    endfunction

    // Register 0 is hard zero; a committing write to the same index wins over the array.
    function automatic logic [WORD_LEN-1:0] read_port(
        input logic [ADDR_LEN-1:0] idx,
        input logic [WORD_LEN-1:0] stored,
        input logic [ADDR_LEN-1:0] dest,
        input logic                valid,
        input logic [WORD_LEN-1:0] wbd
    );
        logic [WORD_LEN-1:0] res;
        if (idx == {ADDR_LEN{1'b0}}) begin
            res = {WORD_LEN{1'b0}};
        end else if (valid && (idx == dest)) begin
            res = wbd;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    logic [WORD_LEN-1:0]  r_regs [REG_COUNT];
    logic [COUNT_LEN-1:0] r_commit_count;
    logic [WORD_LEN-1:0]  w_wb_data;
    logic                 w_wb_valid;
    logic [WORD_LEN-1:0]  w_read_data1;
    logic [WORD_LEN-1:0]  w_read_data2;

    // Write-back value selection and commit qualification
    always_comb begin
        w_wb_data  = wb_select(bus.reg_data_sel, bus.alu_result, bus.mem_read_data,
                               bus.next_pc, bus.less_than);
        w_wb_valid = bus.reg_write_en && (bus.reg_dest != {ADDR_LEN{1'b0}});
    end

    // Read ports with same-cycle bypass
    always_comb begin
        w_read_data1 = read_port(bus.read_reg1, r_regs[bus.read_reg1], bus.reg_dest,
                                 w_wb_valid, w_wb_data);
        w_read_data2 = read_port(bus.read_reg2, r_regs[bus.read_reg2], bus.reg_dest,
                                 w_wb_valid, w_wb_data);
    end

    // Register array commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= {WORD_LEN{1'b0}};
            end
        end else if (w_wb_valid) begin
            r_regs[bus.reg_dest] <= w_wb_data;
        end
    end

    // Committed-write counter, wraps silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_commit_count <= {COUNT_LEN{1'b0}};
        end else if (w_wb_valid) begin
            r_commit_count <= r_commit_count + {{(COUNT_LEN-1){1'b0}}, 1'b1};
        end
    end

    assign bus.wb_data      = w_wb_data;
    assign bus.wb_valid     = w_wb_valid;
    assign bus.read_data1   = w_read_data1;
    assign bus.read_data2   = w_read_data2;
    assign bus.commit_count = r_commit_count;

endmodule
